ped_spawner: RTL and testbench

//  Pedestrian source for the control FSM. Spawns a pedestrian at a pseudo-random

---
 rtl/game_pkg.sv | 23 ++
 rtl/lfsr9.sv | 18 +
 rtl/ped_spawner.sv | 164 ++++++++++++++++
 tb/tb_ped_spawner.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants: FSM state encoding, screen geometry and sprite sizes,
// used by the pedestrian spawner and by the datapath x_max/y_max limits.
package game_pkg;

   typedef enum logic [1:0] {
      WAIT_SPAWN = 2'd0,
      WALK       = 2'd1,
      REQ        = 2'd2,
      CHECK      = 2'd3
   } ped_state_t;

   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;

   localparam int CAR_SPRITE_W = 27;
   localparam int CAR_SPRITE_H = 48;
   localparam int PED_SPRITE_W = 10;
   localparam int PED_SPRITE_H = 17;

   // Rightmost spawn column keeps the pedestrian on the road surface.
   localparam int ROAD_RIGHT_MARGIN = 50;

endpackage

// File: rtl/lfsr9.sv
// 9-bit Fibonacci LFSR, polynomial x^9+x^5+1, advancing every clock.
// Loads seed on reset; shared by the pedestrian and traffic sources.
module lfsr9 (
   input  logic       clock,
   input  logic       reset,
   input  logic [8:0] seed,
   output logic [8:0] q
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q <= seed;
      end else begin
         q <= {q[7:0], q[8] ^ q[4]};
      end
   end

endmodule

// File: rtl/ped_spawner.sv
// Pedestrian source: spawns at a pseudo-random column, walks down, requests each
// redraw via move_p/move_ack and reports car hit or bottom miss. PED_SCORE_EN adds score/lives.
module ped_spawner
   import game_pkg::*;
#(
   parameter int         STEP_TICKS  = 2000,
   parameter int         SPAWN_DELAY = 50000,
   parameter int         X_MIN       = 40,
   parameter int         X_MAX       = SCREEN_W - ROAD_RIGHT_MARGIN,
   parameter int         Y_START     = 0,
   parameter int         Y_END       = SCREEN_H - PED_SPRITE_H,
   parameter int         STEP_PX     = 1,
   parameter int         PED_W       = PED_SPRITE_W,
   parameter int         PED_H       = PED_SPRITE_H,
   parameter int         CAR_W       = CAR_SPRITE_W,
   parameter int         CAR_H       = CAR_SPRITE_H,
   parameter logic [8:0] LFSR_SEED   = 9'h1A5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       move_ack,
   input  logic [8:0] car_x,
   input  logic [7:0] car_y,
   output logic [8:0] p_x,
   output logic [7:0] p_y,
   output logic       move_p,
   output logic       active,
   output logic       hit,
   output logic       miss
`ifdef PED_SCORE_EN
   ,
   output logic [7:0] score,
   output logic [1:0] lives
`endif
);

   localparam int SPAWN_W = $clog2(SPAWN_DELAY + 1);
   localparam int STEP_W  = $clog2(STEP_TICKS + 1);
   localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(SPAWN_DELAY - 1);
   localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_TICKS - 1);

   ped_state_t         state_reg;
   logic [SPAWN_W-1:0] spawn_cnt_reg;
   logic [STEP_W-1:0]  step_cnt_reg;
   logic [8:0]         lfsr_q;
   logic               lfsr_unused_msb;
   logic [9:0]         spawn_sum;
   logic [8:0]         spawn_x;
   logic [9:0]         px_w, py_w, cx_w, cy_w, y_next;
   logic               overlap;
   logic               spawn_allowed;

   lfsr9 u_lfsr (
      .clock (clock),
      .reset (reset),
      .seed  (LFSR_SEED),
      .q     (lfsr_q)
   );

   assign lfsr_unused_msb = lfsr_q[8];

   // Only the low byte picks the column; overshoot is clamped to the right edge.
   assign spawn_sum = 10'(X_MIN) + {2'b00, lfsr_q[7:0]};
   assign spawn_x   = (spawn_sum > 10'(X_MAX)) ? 9'(X_MAX) : spawn_sum[8:0];

   assign px_w   = {1'b0, p_x};
   assign py_w   = {2'b00, p_y};
   assign cx_w   = {1'b0, car_x};
   assign cy_w   = {2'b00, car_y};
   assign y_next = py_w + 10'(STEP_PX);

   // Half-open box intersection; 10-bit sums cannot wrap for 9/8-bit positions.
   assign overlap = (px_w < cx_w + 10'(CAR_W)) && (cx_w < px_w + 10'(PED_W)) &&
                    (py_w < cy_w + 10'(CAR_H)) && (cy_w < py_w + 10'(PED_H));

`ifdef PED_SCORE_EN
   assign spawn_allowed = (lives != 2'd0);
`else
   assign spawn_allowed = 1'b1;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg     <= WAIT_SPAWN;
         spawn_cnt_reg <= '0;
         step_cnt_reg  <= '0;
         p_x           <= 9'(X_MIN);
         p_y           <= 8'(Y_START);
         move_p        <= 1'b0;
         active        <= 1'b0;
         hit           <= 1'b0;
         miss          <= 1'b0;
`ifdef PED_SCORE_EN
         score         <= 8'd0;
         lives         <= 2'd3;
`endif
      end else begin
         hit  <= 1'b0;
         miss <= 1'b0;
         case (state_reg)
            WAIT_SPAWN: begin
               if (enable && spawn_allowed) begin
                  if (spawn_cnt_reg == SPAWN_LAST) begin
                     spawn_cnt_reg <= '0;
                     p_x           <= spawn_x;
                     p_y           <= 8'(Y_START);
                     active        <= 1'b1;
                     state_reg     <= REQ;
                  end else begin
                     spawn_cnt_reg <= spawn_cnt_reg + SPAWN_W'(1);
                  end
               end
            end
            WALK: begin
               if (enable) begin
                  if (step_cnt_reg == STEP_LAST) begin
                     step_cnt_reg <= '0;
                     if (y_next > 10'(Y_END)) begin
                        miss          <= 1'b1;
                        active        <= 1'b0;
                        spawn_cnt_reg <= '0;
                        state_reg     <= WAIT_SPAWN;
`ifdef PED_SCORE_EN
                        if (lives != 2'd0) lives <= lives - 2'd1;
`endif
                     end else begin
                        p_y       <= y_next[7:0];
                        state_reg <= REQ;
                     end
                  end else begin
                     step_cnt_reg <= step_cnt_reg + STEP_W'(1);
                  end
               end
            end
            REQ: begin
               // An ack only counts once the request is actually visible.
               if (move_p && move_ack) begin
                  move_p    <= 1'b0;
                  state_reg <= CHECK;
               end else begin
                  move_p <= 1'b1;
               end
            end
            CHECK: begin
               if (overlap) begin
                  hit           <= 1'b1;
                  active        <= 1'b0;
                  spawn_cnt_reg <= '0;
                  state_reg     <= WAIT_SPAWN;
`ifdef PED_SCORE_EN
                  if (score != 8'd255) score <= score + 8'd1;
`endif
               end else begin
                  step_cnt_reg <= '0;
                  state_reg    <= WALK;
               end
            end
            default: state_reg <= WAIT_SPAWN;
         endcase
      end
   end

endmodule

// File: tb/tb_ped_spawner.sv
// Self-checking bench for ped_spawner: directed sequences, a vector table of car
// placements, and randomized traffic checked cycle by cycle against a behavioural model.
module tb_ped_spawner;

   localparam int STEP  = 3;
   localparam int SPAWN = 4;
   localparam int PH_WAIT = 0, PH_WALK = 1, PH_REQ = 2, PH_CHECK = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       move_ack = 1'b0;
   logic [8:0] car_x = 9'd0;
   logic [7:0] car_y = 8'd200;
   logic [8:0] p_x;
   logic [7:0] p_y;
   logic       move_p, active, hit, miss;
`ifdef PED_SCORE_EN
   logic [7:0] score;
   logic [1:0] lives;
`endif

   ped_spawner #(.STEP_TICKS(STEP), .SPAWN_DELAY(SPAWN)) dut (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .move_ack (move_ack),
      .car_x    (car_x),
      .car_y    (car_y),
      .p_x      (p_x),
      .p_y      (p_y),
      .move_p   (move_p),
      .active   (active),
      .hit      (hit),
      .miss     (miss)
`ifdef PED_SCORE_EN
      ,
      .score    (score),
      .lives    (lives)
`endif
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   int hits_seen = 0;
   int misses_seen = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int       m_phase, m_left, m_x, m_y, m_score, m_lives;
   bit       m_move, m_active, m_hit, m_miss;
   logic [8:0] m_lfsr;

   function automatic logic [8:0] lfsr_next(input logic [8:0] q);
      return {q[7:0], q[8] ^ q[4]};   // x^9 + x^5 + 1
   endfunction

   function automatic logic [8:0] lfsr_after(input int n);
      logic [8:0] q = 9'h1A5;
      for (int i = 0; i < n; i++) q = lfsr_next(q);
      return q;
   endfunction

   function automatic int spawn_col(input logic [8:0] q);
      int x = 40 + int'(q[7:0]);
      return (x > 270) ? 270 : x;
   endfunction

   function automatic bit boxes_touch(input int px, input int py, input int cx, input int cy);
      return (px < cx + 27) && (cx < px + 10) && (py < cy + 48) && (cy < py + 17);
   endfunction

   task automatic model_reset();
      m_phase = PH_WAIT; m_left = SPAWN; m_lfsr = 9'h1A5;
      m_x = 40; m_y = 0; m_move = 0; m_active = 0; m_hit = 0; m_miss = 0;
      m_score = 0; m_lives = 3;
   endtask

   task automatic model_step();
      logic [8:0] cur = m_lfsr;
      m_lfsr = lfsr_next(m_lfsr);
      m_hit = 0;
      m_miss = 0;
      case (m_phase)
         PH_WAIT: if (enable && m_lives > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_x = spawn_col(cur); m_y = 0; m_active = 1; m_phase = PH_REQ;
            end
         end
         PH_REQ: if (m_move && move_ack) begin
            m_move = 0; m_phase = PH_CHECK;
         end else m_move = 1;
         PH_CHECK: if (boxes_touch(m_x, m_y, int'(car_x), int'(car_y))) begin
            m_hit = 1; m_active = 0; m_phase = PH_WAIT; m_left = SPAWN;
            if (m_score < 255) m_score++;
         end else begin
            m_phase = PH_WALK; m_left = STEP;
         end
         default: if (enable) begin
            m_left--;
            if (m_left == 0) begin
               if (m_y + 1 > 223) begin
                  m_miss = 1; m_active = 0; m_phase = PH_WAIT; m_left = SPAWN;
`ifdef PED_SCORE_EN
                  m_lives--;
`endif
               end else begin
                  m_y++; m_phase = PH_REQ;
               end
            end
         end
      endcase
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clock or posedge reset);
         if (reset) model_reset();
         else model_step();
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clock);
         check("cycle", 32'({p_x, p_y, move_p, active, hit, miss}),
               32'({9'(m_x), 8'(m_y), m_move, m_active, m_hit, m_miss}));
`ifdef PED_SCORE_EN
         check("score", 32'(score), 32'(m_score));
         check("lives", 32'(lives), 32'(m_lives));
`endif
         if (hit) hits_seen++;
         if (miss) misses_seen++;
      end
   end

   // ---------------- ack responder ----------------
   bit auto_ack = 0;
   bit spurious = 0;
   int ack_max = 0;
   int ack_wait = 0;
   int ack_delay = 0;

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (reset) begin
            move_ack = 1'b0;
         end else if (auto_ack && move_p) begin
            if (ack_wait >= ack_delay) move_ack = 1'b1;
            else begin
               move_ack = 1'b0;
               ack_wait++;
            end
         end else begin
            ack_wait = 0;
            ack_delay = $urandom_range(0, ack_max);
            move_ack = spurious && ($urandom_range(0, 7) == 0);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic do_reset(input bit en);
      tick();
      reset = 1'b1;
      enable = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      enable = en;
   endtask

   task automatic wait_move(input int limit, input string name, output int k);
      k = 0;
      while (move_p !== 1'b1 && k < limit) begin
         tick();
         k++;
      end
      if (move_p !== 1'b1) check({name, "_timeout"}, 32'(move_p), 32'd1);
   endtask

   task automatic wait_pulse(input int limit, input string name);
      int k = 0;
      while (!(hit || miss) && k < limit) begin
         tick();
         k++;
      end
      if (!(hit || miss)) check({name, "_timeout"}, 32'(hit | miss), 32'd1);
   endtask

   typedef struct {
      bit abs_x;
      int car_x;
      int car_y;
      bit exp_hit;
      int exp_y;
   } vec_t;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish by time limit, want finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[9];
      int   k;

      vecs[0] = '{1,   0, 200, 0, 223};   // car far left: full walk, one miss
      vecs[1] = '{0,   0,  20, 1,   4};   // 4+17 > 20
      vecs[2] = '{0,  10,  20, 0, 223};   // right edge adjacent
      vecs[3] = '{0,   9,  20, 1,   4};
      vecs[4] = '{0, -27,  20, 0, 223};   // left edge adjacent
      vecs[5] = '{0, -26,  20, 1,   4};
      vecs[6] = '{0,   0,   0, 1,   0};   // overlap at the very first check
      vecs[7] = '{0,   0, 230, 1, 214};
      vecs[8] = '{0,   0, 240, 0, 223};   // car just below the last row

      // Reset, game not running.
      do_reset(1'b0);
      hits_seen = 0;
      misses_seen = 0;
      repeat (100) tick();
      check("idle_p_x", 32'(p_x), 32'd40);
      check("idle_p_y", 32'(p_y), 32'd0);
      check("idle_move_p", 32'(move_p), 32'd0);
      check("idle_active", 32'(active), 32'd0);
      check("idle_hits", 32'(hits_seen), 32'd0);
      check("idle_misses", 32'(misses_seen), 32'd0);

      // Spawn latency, request held while ack withheld, ack honoured with enable low.
      car_x = 9'd0;
      car_y = 8'd200;
      auto_ack = 0;
      do_reset(1'b1);
      wait_move(20, "spawn", k);
      check("spawn_latency", 32'(k), 32'd5);
      check("spawn_x", 32'(p_x), 32'(spawn_col(lfsr_after(3))));
      repeat (50) tick();
      check("withheld_move_p", 32'(move_p), 32'd1);
      check("withheld_p_y", 32'(p_y), 32'd0);
      enable = 1'b0;
      auto_ack = 1;
      k = 0;
      while (move_p && k < 10) begin
         tick();
         k++;
      end
      check("ack_while_disabled", 32'(move_p), 32'd0);
      repeat (20) tick();
      check("frozen_p_y", 32'(p_y), 32'd0);
      check("frozen_move_p", 32'(move_p), 32'd0);
      check("frozen_active", 32'(active), 32'd1);
      enable = 1'b1;
      wait_move(20, "resume", k);
      check("resume_latency", 32'(k), 32'(STEP + 1));
      check("step_p_y", 32'(p_y), 32'd1);

      // Reset during a pending request drops move_p without a clock edge.
      auto_ack = 0;
      do_reset(1'b1);
      wait_move(20, "req_reset", k);
      reset = 1'b1;
      #1;
      check("reset_drops_move_p", 32'(move_p), 32'd0);
      check("reset_drops_active", 32'(active), 32'd0);
      repeat (2) tick();
      reset = 1'b0;
      auto_ack = 1;

      // Car placement table.
      for (int i = 0; i < 9; i++) begin
         car_x = 9'd0;
         car_y = 8'd200;
         do_reset(1'b1);
         wait_move(20, $sformatf("vec%0d_spawn", i), k);
         car_x = vecs[i].abs_x ? 9'(vecs[i].car_x) : 9'(m_x + vecs[i].car_x);
         car_y = 8'(vecs[i].car_y);
         wait_pulse(3000, $sformatf("vec%0d", i));
         check($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
         check($sformatf("vec%0d_miss", i), 32'(miss), 32'(!vecs[i].exp_hit));
         check($sformatf("vec%0d_p_y", i), 32'(p_y), 32'(vecs[i].exp_y));
         check($sformatf("vec%0d_active", i), 32'(active), 32'd0);
      end

      // Randomized enable, ack delays, stray acks and car positions.
      ack_max = 3;
      spurious = 1;
      for (int blk = 0; blk < 4; blk++) begin
         do_reset(1'b1);
         car_x = 9'($urandom_range(13, 290));
         car_y = 8'($urandom_range(0, 240));
         for (int c = 0; c < 1500; c++) begin
            tick();
            enable = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 199) == 0) begin
               car_x = 9'($urandom_range(13, 290));
               car_y = 8'($urandom_range(0, 240));
            end
         end
      end
      ack_max = 0;
      spurious = 0;

`ifdef PED_SCORE_EN
      // Two hits then three misses: lives run out and spawning stops.
      do_reset(1'b1);
      for (int h = 0; h < 2; h++) begin
         car_x = 9'd0;
         car_y = 8'd200;
         wait_move(50, "score_spawn", k);
         car_x = 9'(m_x);
         car_y = 8'd0;
         wait_pulse(50, "score_hit");
         check("score_hit_pulse", 32'(hit), 32'd1);
      end
      car_x = 9'd0;
      car_y = 8'd200;
      for (int m = 0; m < 3; m++) begin
         tick();
         wait_pulse(3000, "lives_miss");
         check("lives_after_miss", 32'(lives), 32'(2 - m));
      end
      check("final_score", 32'(score), 32'd2);
      k = 0;
      repeat (200) begin
         tick();
         if (move_p) k++;
      end
      check("no_move_after_lives", 32'(k), 32'd0);
      check("no_active_after_lives", 32'(active), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
